rally_ctrl: RTL and testbench
=============================

# rally_ctrl

Game sequencer for the pong ball datapath. It holds the ball centred during a serve delay, then releases it at a starting speed, optionally ramping speed during a rally. It converts `out_left`/`out_right` edge events into scores and ends the game at a configurable winning score. It sits between the player start button and the ball block, driving the ball's `ball_reset` and `speed` inputs on the same 2 kHz game clock.

## Interface
- `WIN_SCORE`, 9: points needed to win; legal 1..15.
- `SERVE_TICKS`, 2000: cycles the ball is held centred before each serve; legal 1..65535.
- `START_SPEED`, 4: speed at serve; legal 1..15.
- `MAX_SPEED`, 15: ramp ceiling; legal START_SPEED..15.
- `RAMP_TICKS`, 4000: rally cycles per speed increment; legal 1..65535.

- `clk`  in  1  game clock, 2 kHz nominal.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  synchronous level; begins a game from IDLE or OVER.
- `out_left`  in  1  from ball: ball left via left edge; right player scores.
- `out_right`  in  1  from ball: ball left via right edge; left player scores.
- `ball_reset`  out  1  to ball: recentre and re-randomise direction.
- `speed`  out  4  to ball: ball speed; 0 freezes the ball.
- `score_l`  out  4  left player score.
- `score_r`  out  4  right player score.
- `game_over`  out  1  high in OVER.
- `winner`  out  1  valid while `game_over`: 0 = left, 1 = right.

## Operation
- All outputs are registered. `ball_reset` = 1 and `speed` = 0 in every state except PLAY.
- States: IDLE, SERVE, PLAY, OVER. Reset enters IDLE with `score_l` = `score_r` = 0, `game_over` = 0, `winner` = 0, and all counters at 0.
- IDLE: when `start` = 1, go to SERVE, clear both scores, and set `tick` = 0.
- SERVE: `tick` increments each cycle. When `tick` = SERVE_TICKS-1, go to PLAY and set `speed` = START_SPEED, `ramp` = 0. `start` is ignored.
- PLAY, `out_left` alone:
  - `score_r`+1.
  - If the new value equals WIN_SCORE, go to OVER with `winner` = 1.
  - Otherwise go to SERVE with `tick` = 0.
- PLAY, `out_right` alone: symmetric, incrementing `score_l` with `winner` = 0.
- PLAY, both asserted in the same cycle: no score; go to SERVE (replay).
- PLAY, no event: speed ramp per Configuration. `start` is ignored.
- OVER: scores and `winner` are held and `game_over` = 1. When `start` = 1, go to SERVE, clear scores, and set `game_over` = 0.
- `out_left`/`out_right` are ignored outside PLAY.
- Score arithmetic is 4-bit. WIN_SCORE ≤ 15 guarantees no wrap.

## Timing
- Event in PLAY sampled at edge k: after edge k, `ball_reset` = 1, `speed` = 0, and the score is updated. Latency is 1 cycle.
- Serve length: `ball_reset` is high for exactly SERVE_TICKS cycles counted from SERVE entry. The first cycle with `ball_reset` = 0 has `speed` = START_SPEED.
- `start` in IDLE/OVER at edge k: SERVE is entered after edge k, and scores read 0 from that cycle.
- `reset` mid-operation: all outputs go immediately (asynchronously) to IDLE values: `ball_reset` = 1, `speed` = 0, scores 0, `game_over` = 0, `winner` = 0.
- Counters `tick` and `ramp` are 16 bits and never exceed their parameter minus 1.

## Configuration
- `RALLY_CTRL_SPEED_RAMP_EN` defined:
  - In PLAY, `ramp` increments each cycle without an event.
  - When `ramp` = RAMP_TICKS-1, it wraps to 0 and `speed` increments, saturating at MAX_SPEED.
  - `speed` returns to START_SPEED at the next serve.
- Not defined: no `ramp` counter is built, `speed` stays START_SPEED throughout PLAY, and RAMP_TICKS and MAX_SPEED are unused.

## Test plan
- Reset, then IDLE for 10 cycles -> `ball_reset` = 1, `speed` = 0, scores 0, `game_over` = 0. Pulse `start` -> `ball_reset` stays 1 for exactly SERVE_TICKS cycles, then drops with `speed` = 4.
- In PLAY, pulse `out_left` -> next cycle `score_r` = 1, `ball_reset` = 1, `speed` = 0. After SERVE_TICKS cycles, PLAY resumes. Repeat with `out_right` -> `score_l` = 1.
- Drive 9 `out_right` events -> after the 9th: `game_over` = 1, `winner` = 0, `score_l` = 9. Further `out_left` pulses leave `score_r` unchanged. `start` -> scores 0, `game_over` = 0, SERVE entered.
- `out_left` and `out_right` in the same PLAY cycle -> scores unchanged, SERVE entered. Events during SERVE or IDLE -> ignored.
- With `RALLY_CTRL_SPEED_RAMP_EN`, RAMP_TICKS = 10 -> `speed` goes 4, 5, … every 10 cycles and saturates at 15; resets to 4 after a point. Without the macro -> `speed` stays 4 for 200 PLAY cycles.
- Assert `reset` mid-PLAY with scores 3/5 -> outputs immediately show IDLE values. Deassert -> IDLE persists until `start`.

Source files
------------

// File: rtl/rally_ctrl.sv
// Pong game sequencer: serve delay, rally, scoring and game-over detection.
// Optional speed ramp during a rally is enabled by RALLY_CTRL_SPEED_RAMP_EN.
module rally_ctrl #(
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned SERVE_TICKS = 2000,
    parameter int unsigned START_SPEED = 4,
    parameter int unsigned MAX_SPEED   = 15,
    parameter int unsigned RAMP_TICKS  = 4000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       out_left,
    input  logic       out_right,
    output logic       ball_reset,
    output logic [3:0] speed,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

    localparam logic [15:0] SERVE_LAST = 16'(SERVE_TICKS - 1);
    localparam logic [3:0]  START_SPD  = 4'(START_SPEED);
    localparam logic [3:0]  WIN_PTS    = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [3:0]  speed_q, speed_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic        ball_reset_q, ball_reset_d;
    logic        game_over_q, game_over_d;
    logic        winner_q, winner_d;

`ifdef RALLY_CTRL_SPEED_RAMP_EN
    localparam logic [15:0] RAMP_LAST = 16'(RAMP_TICKS - 1);
    localparam logic [3:0]  MAX_SPD   = 4'(MAX_SPEED);

    logic [15:0] ramp_q, ramp_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ramp_q <= '0;
        else       ramp_q <= ramp_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            speed_q      <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            speed_q      <= speed_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        speed_d     = speed_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
`ifdef RALLY_CTRL_SPEED_RAMP_EN
        ramp_d      = ramp_q;
`endif
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d     = SERVE;
                    tick_d      = '0;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    game_over_d = 1'b0;
                end
            end
            SERVE: begin
                if (tick_q == SERVE_LAST) begin
                    state_d = PLAY;
                    tick_d  = '0;
                    speed_d = START_SPD;
`ifdef RALLY_CTRL_SPEED_RAMP_EN
                    ramp_d  = '0;
`endif
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            PLAY: begin
                case ({out_left, out_right})
                    2'b10: begin
                        score_r_d = score_r_q + 4'd1;
                        if (score_r_d == WIN_PTS) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                        end else begin
                            state_d = SERVE;
                            tick_d  = '0;
                        end
                    end
                    2'b01: begin
                        score_l_d = score_l_q + 4'd1;
                        if (score_l_d == WIN_PTS) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                        end else begin
                            state_d = SERVE;
                            tick_d  = '0;
                        end
                    end
                    2'b11: begin
                        state_d = SERVE;
                        tick_d  = '0;
                    end
                    default: begin
`ifdef RALLY_CTRL_SPEED_RAMP_EN
                        if (ramp_q == RAMP_LAST) begin
                            ramp_d = '0;
                            if (speed_q < MAX_SPD) speed_d = speed_q + 4'd1;
                        end else begin
                            ramp_d = ramp_q + 16'd1;
                        end
`endif
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase

        // Ball outputs are registered from the next state so they line up with it.
        ball_reset_d = (state_d != PLAY);
        if (state_d != PLAY) speed_d = '0;
    end

    assign ball_reset = ball_reset_q;
    assign speed      = speed_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Self-checking bench for rally_ctrl: vector table plus hand-written game sequences.
module tb_rally_ctrl;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       out_left = 1'b0;
    logic       out_right = 1'b0;
    logic       ball_reset;
    logic [3:0] speed, score_l, score_r;
    logic       game_over, winner;

    rally_ctrl #(
        .WIN_SCORE(9),
        .SERVE_TICKS(S),
        .START_SPEED(4),
        .MAX_SPEED(15),
        .RAMP_TICKS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .out_left(out_left),
        .out_right(out_right),
        .ball_reset(ball_reset),
        .speed(speed),
        .score_l(score_l),
        .score_r(score_r),
        .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, ol, orr;
        logic       br;
        logic [3:0] sp, sl, sr;
        logic       go, w;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(logic st, logic ol, logic orr, logic br, logic [3:0] sp,
                                logic [3:0] sl, logic [3:0] sr, logic go, logic w);
        vec_t v;
        v.st = st; v.ol = ol; v.orr = orr; v.br = br; v.sp = sp;
        v.sl = sl; v.sr = sr; v.go = go; v.w = w;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic compare_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        chk("ball_reset", int'(ball_reset), int'(e.br));
        chk("speed",      int'(speed),      int'(e.sp));
        chk("score_l",    int'(score_l),    int'(e.sl));
        chk("score_r",    int'(score_r),    int'(e.sr));
        chk("game_over",  int'(game_over),  int'(e.go));
        chk("winner",     int'(winner),     int'(e.w));
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        start = v.st; out_left = v.ol; out_right = v.orr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic serve(input logic [3:0] sl, input logic [3:0] sr);
        for (int i = 0; i < int'(S) - 1; i++) step(mk(0, 0, 0, 1, 0, sl, sr, 0, 0));
        step(mk(0, 0, 0, 0, 4, sl, sr, 0, 0));
    endtask

    initial begin
        logic [3:0] sl, sr, esp;

        // Reset values while reset is held, then 10 idle cycles.
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        compare_out();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

        // start, SERVE length, single-sided points, simultaneous replay, ignored inputs.
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4, 1, 1, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Left player wins on the 9th point.
        for (int k = 2; k <= 9; k++) begin
            step(mk(0, 0, 1, 1, 0, 4'(k), 1, (k == 9), 0));
            if (k < 9) serve(4'(k), 1);
        end
        for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 1, 0, 9, 1, 1, 0));
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        serve(0, 0);

        // Rally speed over 200 event-free PLAY cycles.
        for (int m = 1; m <= 200; m++) begin
`ifdef RALLY_CTRL_SPEED_RAMP_EN
            esp = (4 + m / 10 > 15) ? 4'd15 : 4'(4 + m / 10);
`else
            esp = 4'd4;
`endif
            step(mk(0, 0, 0, 0, esp, 0, 0, 0, 0));
        end
        step(mk(0, 1, 0, 1, 0, 0, 1, 0, 0));
        serve(0, 1);

        // Build up a 3/5 score, then reset asynchronously mid-PLAY.
        sl = 0;
        sr = 1;
        for (int i = 0; i < 3; i++) begin
            sl++;
            step(mk(0, 0, 1, 1, 0, sl, sr, 0, 0));
            serve(sl, sr);
        end
        for (int i = 0; i < 4; i++) begin
            sr++;
            step(mk(0, 1, 0, 1, 0, sl, sr, 0, 0));
            serve(sl, sr);
        end
        step(mk(0, 0, 0, 0, 4, 3, 5, 0, 0));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        compare_out();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(mk(0, i[0], ~i[0], 1, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        serve(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
